// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the N-port bus arbiter.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package bus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      POP     = 2'd1,
      DELIVER = 2'd2
   } state_e;

   localparam int                  ID_W_DEF  = 8;
   localparam logic [ID_W_DEF-1:0] BCAST_DEF = 8'hFF;

   // Upper bounds used by the width-generic helpers below.
   localparam int MAX_PKT   = 64;
   localparam int MAX_PKT_W = 6;
   localparam int MAX_ID    = 16;
   localparam int MAX_DRV   = 16;
   localparam int MAX_DRV_W = 4;

   // Destination field: the id_w bits at the top of a pkt_w-bit packet.
   function automatic logic [MAX_ID-1:0] get_dest(input logic [MAX_PKT-1:0] pkt,
                                                   input int pkt_w,
                                                   input int id_w);
      logic [MAX_ID-1:0] r;
      r = '0;
      for (int b = 0; b < MAX_ID; b++) begin
         if (b < id_w) r[MAX_DRV_W'(b)] = pkt[MAX_PKT_W'(pkt_w - id_w + b)];
      end
      return r;
   endfunction

   // Receiver set for a packet; an all-zero result means the packet is dropped.
   function automatic logic [MAX_DRV-1:0] target_mask(input logic [MAX_ID-1:0] dest,
                                                       input int src,
                                                       input int drvrs,
                                                       input logic [MAX_ID-1:0] bcast);
      logic [MAX_DRV-1:0] m;
      m = '0;
      if (dest == bcast) begin
         for (int i = 0; i < MAX_DRV; i++) begin
            if (i < drvrs && i != src) m[MAX_DRV_W'(i)] = 1'b1;
         end
      end else if (int'(dest) < drvrs) begin
         m[dest[MAX_DRV_W-1:0]] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/bus_rr_arbiter_n_rr_arbiter.sv
// Request selector: round-robin from rr_ptr or fixed lowest-index priority.
// Latency: combinational grant; rr_ptr moves on the clock after an advance.
// Backpressure: none; the caller decides when a grant is consumed (advance).
module rr_arbiter #(
   parameter int drvrs = 4,
   localparam int IDX_W = $clog2(drvrs)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [drvrs-1:0] req,
   input  logic             mode,
   input  logic             advance,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid
);

   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W:0]   sum;
   logic             found;

   // Winner search: wrap from rr_ptr in round-robin, from index 0 in fixed priority.
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      sum     = '0;
      for (int k = 0; k < drvrs; k++) begin
         if (mode) begin
            sum = (IDX_W+1)'(k);
         end else begin
            sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(drvrs)) sum = sum - (IDX_W+1)'(drvrs);
         end
         if (!found && req[sum[IDX_W-1:0]]) begin
            found   = 1'b1;
            gnt_idx = sum[IDX_W-1:0];
         end
      end
      gnt_valid = found;
   end

   // Pointer moves past the winner only for consumed round-robin grants.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (advance && gnt_valid && !mode) begin
         rr_ptr_d = (gnt_idx == IDX_W'(drvrs - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
   end

   // Pointer register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rr_ptr_q <= '0;
      else        rr_ptr_q <= rr_ptr_d;
   end

endmodule

// File: rtl/bus_rr_arbiter_n.sv
// N-port bus arbiter: pops one packet per grant and delivers it to one port or broadcasts.
// Latency: 3 cycles minimum per packet (arbitrate, pop, deliver).
// Backpressure: delivery waits until every target has full low; invalid IDs are counted and dropped.
module bus_rr_arbiter_n
   import bus_arb_pkg::*;
#(
   parameter int              drvrs   = 4,
   parameter int              pckg_sz = 16,
   parameter int              ID_W    = ID_W_DEF,
   parameter logic [ID_W-1:0] BCAST   = ID_W'(BCAST_DEF),
   parameter int              CNT_W   = 16,
   localparam int             IDX_W   = $clog2(drvrs)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [drvrs-1:0]                pndng,
   input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
   output logic [drvrs-1:0]                pop,
   output logic [drvrs-1:0]                push,
   output logic [drvrs-1:0][pckg_sz-1:0]   D_push,
   input  logic [drvrs-1:0]                full,
   input  logic                            mode,
   output logic [IDX_W-1:0]                grant_id,
   output logic                            bus_busy,
   output logic [CNT_W-1:0]                drop_cnt
);

   state_e                          state_q, state_d;
   logic [IDX_W-1:0]                grant_q, grant_d;
   logic [pckg_sz-1:0]              hold_q, hold_d;
   logic [CNT_W-1:0]                drop_cnt_q, drop_cnt_d;
   logic [drvrs-1:0][pckg_sz-1:0]   d_push_q, d_push_d;

   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_valid;
   logic               advance;
   logic [MAX_ID-1:0]  dest;
   logic [MAX_DRV-1:0] tmask_full;
   logic [drvrs-1:0]   tmask;
   logic               drop_pkt;
   logic               tgt_rdy;
   logic [drvrs-1:0]   push_o;

   assign advance = (state_q == IDLE);

   rr_arbiter #(.drvrs(drvrs)) u_arb (
      .clk       (clk),
      .reset     (reset),
      .req       (pndng),
      .mode      (mode),
      .advance   (advance),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   // Decode the latched packet into its receiver set and readiness.
   always_comb begin
      dest       = get_dest(MAX_PKT'(hold_q), pckg_sz, ID_W);
      tmask_full = target_mask(dest, int'(grant_q), drvrs, MAX_ID'(BCAST));
      tmask      = tmask_full[drvrs-1:0];
      drop_pkt   = (tmask_full == '0);
      tgt_rdy    = ((full & tmask) == '0);
   end

   // Next state: a packet always passes through POP; DELIVER leaves on drop or push.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (gnt_valid) state_d = POP;
         POP:     state_d = DELIVER;
         DELIVER: if (drop_pkt || tgt_rdy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs: pop for the granted source in POP, push to all targets once they are ready.
   always_comb begin
      pop    = '0;
      push_o = '0;
      if (state_q == POP) pop[grant_q] = 1'b1;
      if (state_q == DELIVER && !drop_pkt && tgt_rdy) push_o = tmask;
      push = push_o;
      for (int i = 0; i < drvrs; i++) begin
         D_push[IDX_W'(i)] = push_o[IDX_W'(i)] ? hold_q : d_push_q[IDX_W'(i)];
      end
      grant_id = grant_q;
      bus_busy = (state_q != IDLE);
      drop_cnt = drop_cnt_q;
   end

   // Datapath updates: latch the winner, count drops, remember last data per receiver.
   always_comb begin
      grant_d    = grant_q;
      hold_d     = hold_q;
      drop_cnt_d = drop_cnt_q;
      d_push_d   = d_push_q;
      if (state_q == IDLE && gnt_valid) begin
         grant_d = gnt_idx;
         hold_d  = D_pop[gnt_idx];
      end
      if (state_q == DELIVER && drop_pkt && drop_cnt_q != '1) begin
         drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
      for (int i = 0; i < drvrs; i++) begin
         if (push_o[IDX_W'(i)]) d_push_d[IDX_W'(i)] = hold_q;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant_q    <= '0;
         hold_q     <= '0;
         drop_cnt_q <= '0;
         d_push_q   <= '0;
      end else begin
         grant_q    <= grant_d;
         hold_q     <= hold_d;
         drop_cnt_q <= drop_cnt_d;
         d_push_q   <= d_push_d;
      end
   end

endmodule

// File: tb/tb_bus_rr_arbiter_n.sv
// Bench for bus_rr_arbiter_n: directed scenarios plus random traffic against a packet-level model.
// Latency: model expects arbitrate, pop next cycle, deliver once all targets are not full.
// Backpressure: full is driven by the bench; per-port queues emulate FWFT source FIFOs.
module tb_bus_rr_arbiter_n;

   logic             clk;
   logic             reset = 1'b1;
   logic [3:0]       pndng;
   logic [3:0][15:0] D_pop;
   logic [3:0]       pop, push;
   logic [3:0][15:0] D_push;
   logic [3:0]       full;
   logic             mode;
   logic [1:0]       grant_id;
   logic             bus_busy;
   logic [15:0]      drop_cnt;

   logic [3:0]       pop2, push2;
   logic [3:0][15:0] D_push2;
   logic [1:0]       grant_id2;
   logic             bus_busy2;
   logic [1:0]       drop_cnt2;

   bus_rr_arbiter_n #(.drvrs(4), .pckg_sz(16)) dut (
      .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop),
      .push(push), .D_push(D_push), .full(full), .mode(mode),
      .grant_id(grant_id), .bus_busy(bus_busy), .drop_cnt(drop_cnt)
   );

   bus_rr_arbiter_n #(.drvrs(4), .pckg_sz(16), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop2),
      .push(push2), .D_push(D_push2), .full(full), .mode(mode),
      .grant_id(grant_id2), .bus_busy(bus_busy2), .drop_cnt(drop_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // source FIFOs and stimulus knobs
   logic [15:0] q [4][$];
   logic [3:0]  full_v;
   logic        mode_v;

   // packet-level reference model
   bit          m_inflight, m_pop_due;
   int          m_src, m_last, m_ptr, m_drop;
   logic [15:0] m_pkt;
   logic [15:0] m_dp [4];

   // observation logs for directed checks
   int               pop_log[$];
   int               pop_cyc[$];
   int               cyc, busy_cnt, push_cnt, push_cyc;
   logic [3:0]       last_push;
   logic [3:0][15:0] last_dp;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int pick_winner(input logic [3:0] r, input logic md, input int ptr);
      int idx;
      for (int k = 0; k < 4; k++) begin
         idx = md ? k : (ptr + k) % 4;
         if (r[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [15:0] rand_pkt();
      int r;
      logic [7:0] d;
      r = $urandom_range(0, 9);
      if (r < 6)      d = 8'(r % 4);
      else if (r < 8) d = 8'hFF;
      else            d = 8'($urandom_range(4, 254));
      return {d, 8'($urandom)};
   endfunction

   task automatic clear_logs();
      pop_log.delete(); pop_cyc.delete();
      cyc = 0; busy_cnt = 0; push_cnt = 0; push_cyc = -1;
      last_push = '0; last_dp = '0;
   endtask

   // One clock: drive at posedge+1, check/model at negedge, dequeue after the pop edge.
   task automatic step();
      logic [3:0]       exp_pop, exp_push, tgt;
      logic [3:0][15:0] exp_dp;
      logic             exp_busy;
      logic [1:0]       exp_gid;
      int               exp_drop, w, dest, deq;
      deq = -1;
      for (int i = 0; i < 4; i++) begin
         pndng[i] = (q[i].size() != 0);
         D_pop[i] = pndng[i] ? q[i][0] : 16'h0;
      end
      full = full_v;
      mode = mode_v;
      @(negedge clk);
      exp_pop  = '0;
      exp_push = '0;
      exp_busy = m_inflight;
      exp_gid  = 2'(m_last);
      exp_drop = m_drop;
      if (!m_inflight) begin
         if (pndng != 0) begin
            w          = pick_winner(pndng, mode_v, m_ptr);
            m_inflight = 1; m_pop_due = 1;
            m_src      = w; m_last = w; m_pkt = q[w][0];
            if (!mode_v) m_ptr = (w + 1) % 4;
         end
      end else if (m_pop_due) begin
         exp_pop   = 4'b0001 << m_src;
         m_pop_due = 0;
         deq       = m_src;
      end else begin
         dest = int'(m_pkt[15:8]);
         if (dest == 255)   tgt = 4'b1111 & ~(4'b0001 << m_src);
         else if (dest < 4) tgt = 4'b0001 << dest;
         else               tgt = 4'b0000;
         if (tgt == 0) begin
            m_inflight = 0;
            if (m_drop < 65535) m_drop++;
         end else if ((full_v & tgt) == 0) begin
            exp_push   = tgt;
            m_inflight = 0;
         end
      end
      for (int i = 0; i < 4; i++) begin
         exp_dp[i] = exp_push[i] ? m_pkt : m_dp[i];
         m_dp[i]   = exp_dp[i];
      end
      chk("pop", pop, exp_pop);
      chk("push", push, exp_push);
      chk("d_push", D_push, exp_dp);
      chk("bus_busy", bus_busy, exp_busy);
      chk("grant_id", grant_id, exp_gid);
      chk("drop_cnt", drop_cnt, exp_drop);
      chk("drop_cnt_sat", drop_cnt2, (exp_drop > 3) ? 3 : exp_drop);
      for (int k = 0; k < 4; k++) begin
         if (pop[k]) begin pop_log.push_back(k); pop_cyc.push_back(cyc); end
      end
      if (push != 0) begin last_push = push; last_dp = D_push; push_cyc = cyc; push_cnt++; end
      if (bus_busy) busy_cnt++;
      cyc++;
      @(posedge clk);
      #1;
      if (deq >= 0) void'(q[deq].pop_front());
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Assert reset (without waiting for a clock), check cleared outputs, release at a negedge.
   task automatic do_reset();
      reset = 1'b0;
      pndng = '0; D_pop = '0; full = '0;
      #1;
      chk("rst_pop", pop, 0);
      chk("rst_push", push, 0);
      chk("rst_busy", bus_busy, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_d_push", D_push, 0);
      m_inflight = 0; m_pop_due = 0; m_ptr = 0; m_last = 0; m_drop = 0;
      for (int i = 0; i < 4; i++) begin m_dp[i] = '0; q[i].delete(); end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int rr_exp[6];
      full = '0; mode = 1'b0; pndng = '0; D_pop = '0;
      full_v = '0; mode_v = 1'b0;
      #2;
      do_reset();

      // single unicast 1 -> 2
      clear_logs();
      q[1].push_back(16'h02AB);
      run(6);
      chk("t1_grant", (pop_log.size() > 0) ? pop_log[0] : -1, 1);
      chk("t1_busy_cycles", busy_cnt, 2);
      chk("t1_push", last_push, 4'b0100);
      chk("t1_dpush2", last_dp[2], 16'h02AB);

      // round-robin with all ports pending
      do_reset();
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 3; k++) q[i].push_back(16'((((i + 1) % 4) << 8) | k));
      mode_v = 1'b0;
      clear_logs();
      run(18);
      rr_exp = '{0, 1, 2, 3, 0, 1};
      chk("rr_npops", pop_log.size(), 6);
      for (int k = 0; k < 6; k++)
         chk("rr_order", (k < pop_log.size()) ? pop_log[k] : -1, rr_exp[k]);
      for (int k = 0; k < 5; k++)
         chk("rr_spacing", (k + 1 < pop_cyc.size()) ? pop_cyc[k+1] - pop_cyc[k] : -1, 3);

      // fixed priority with the same stimulus
      do_reset();
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 3; k++) q[i].push_back(16'((((i + 1) % 4) << 8) | k));
      mode_v = 1'b1;
      clear_logs();
      run(9);
      chk("fp_npops", pop_log.size(), 3);
      for (int k = 0; k < 3; k++)
         chk("fp_order", (k < pop_log.size()) ? pop_log[k] : -1, 0);

      // broadcast from port 3
      do_reset();
      mode_v = 1'b0;
      clear_logs();
      q[3].push_back(16'hFF55);
      run(5);
      chk("bc_push", last_push, 4'b0111);
      for (int i = 0; i < 3; i++) chk("bc_dpush", last_dp[i], 16'hFF55);

      // backpressure: full[2] high for five deliver cycles
      clear_logs();
      q[0].push_back(16'h0234);
      full_v = 4'b0100;
      run(7);
      chk("bp_no_push", push_cnt, 0);
      chk("bp_busy", busy_cnt, 6);
      full_v = 4'b0000;
      run(2);
      chk("bp_push", last_push, 4'b0100);
      chk("bp_delay", (pop_cyc.size() > 0) ? push_cyc - pop_cyc[0] : -1, 6);

      // invalid destination and counter saturation
      do_reset();
      clear_logs();
      for (int k = 0; k < 4; k++) q[2].push_back(16'h0711);
      run(3);
      chk("drop_first", drop_cnt, 1);
      run(10);
      chk("drop_npops", pop_log.size(), 4);
      chk("drop_nopush", push_cnt, 0);
      chk("drop_four", drop_cnt, 4);
      chk("drop_sat_hold", drop_cnt2, 3);

      // reset while stalled in delivery, then arbitration from port 0
      do_reset();
      clear_logs();
      q[1].push_back(16'h0299);
      full_v = 4'b0100;
      run(4);
      chk("pre_rst_busy", bus_busy, 1);
      #1;
      do_reset();
      full_v = 4'b0000;
      clear_logs();
      q[0].push_back(16'h0111);
      q[3].push_back(16'h0122);
      run(3);
      chk("post_rst_first", (pop_log.size() > 0) ? pop_log[0] : -1, 0);

      // random traffic
      for (int t = 0; t < 600; t++) begin
         int p;
         if ($urandom_range(0, 2) == 0) begin
            p = $urandom_range(0, 3);
            if (q[p].size() < 4) q[p].push_back(rand_pkt());
         end
         full_v = 4'($urandom) & 4'($urandom);
         if ($urandom_range(0, 7) == 0) mode_v = ~mode_v;
         step();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
